lsu_mem_ctrl: RTL and testbench

- Parametrised, handshaked load/store unit that replaces the combinational DPI memory stage.
- Accepts one load/store from EXU over valid/ready and issues one aligned, byte-strobed request to a memory port.
- Waits a variable number of cycles for the response, then returns sign- or zero-extended load data (or store completion) to WBU over valid/ready.
- Misaligned accesses are detected and returned as errors without touching memory.

---
 rtl/lsu_mem_ctrl_pkg.sv | 42 ++++
 rtl/lsu_mem_ctrl_if.sv | 57 +++++
 rtl/lsu_mem_ctrl_lane_align.sv | 51 +++++
 rtl/lsu_mem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared funct3 codes, FSM state type and byte-mask helper for
//               the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte-lane mask for an access of 2**size bytes, anchored at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
// ============================================================================
// Module      : lsu_mem_ctrl_if
// Description : EXU request, WBU result and memory port bundle of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_mem_ctrl_if #(
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [2:0]        in_funct3;
    logic [DATA_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata;
    logic              out_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [STRB_W-1:0] mem_req_wstrb;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              mem_rsp_err;

    // LSU view
    modport slave (
        input  in_valid, in_we, in_funct3, in_addr, in_wdata,
        output in_ready,
        output out_valid, out_rdata, out_err,
        input  out_ready,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    // Environment view (EXU + WBU + memory)
    modport master (
        output in_valid, in_we, in_funct3, in_addr, in_wdata,
        input  in_ready,
        input  out_valid, out_rdata, out_err,
        output out_ready,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

endinterface

`default_nettype wire

// File: rtl/lsu_mem_ctrl_lane_align.sv
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane steering: store strobe/data shift and
//               load data extract with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]                      i_funct3,
    input  logic [$clog2(DATA_W/8)-1:0]     i_off,
    input  logic [DATA_W-1:0]               i_wdata,
    input  logic [DATA_W-1:0]               i_rdata,
    output logic [DATA_W/8-1:0]             o_wstrb,
    output logic [DATA_W-1:0]               o_wdata,
    output logic [DATA_W-1:0]               o_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [OFF_W+2:0]  w_bit_sh;
    logic [STRB_W-1:0] w_mask;
    logic [DATA_W-1:0] w_raw_sh;

    assign w_bit_sh = {i_off, 3'b000};
    assign w_mask   = STRB_W'(size_mask(i_funct3[1:0]));
    assign o_wstrb  = w_mask << i_off;
    assign o_wdata  = i_wdata << w_bit_sh;
    assign w_raw_sh = i_rdata >> w_bit_sh;

    always_comb begin
        o_rdata = w_raw_sh;
        case (i_funct3)
            LB:      o_rdata = DATA_W'($signed(w_raw_sh[7:0]));
            LH:      o_rdata = DATA_W'($signed(w_raw_sh[15:0]));
            LW:      o_rdata = DATA_W'($signed(w_raw_sh[31:0]));
            LBU:     o_rdata = DATA_W'(w_raw_sh[7:0]);
            LHU:     o_rdata = DATA_W'(w_raw_sh[15:0]);
            LWU:     o_rdata = DATA_W'(w_raw_sh[31:0]);
            default: o_rdata = w_raw_sh;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
// Module      : lsu_mem_ctrl
// Description : Handshaked load/store unit: one aligned, byte-strobed memory
//               request per EXU transaction, extended result back to WBU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    lsu_mem_ctrl_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_err_q, out_err_d;
    logic [DATA_W-1:0] out_rdata_q, out_rdata_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [STRB_W-1:0] w_wstrb;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_rdata_ext;
    logic [2:0]        w_align_lo;
    logic              w_misalign;
    logic              w_illegal;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_funct3 (funct3_q),
        .i_off    (addr_q[OFF_W-1:0]),
        .i_wdata  (wdata_q),
        .i_rdata  (bus.mem_rsp_rdata),
        .o_wstrb  (w_wstrb),
        .o_wdata  (w_wdata_sh),
        .o_rdata  (w_rdata_ext)
    );

    // Required zero offset bits for a 2**size access: 0, 1, 3, 7.
    always_comb begin
        case (bus.in_funct3[1:0])
            2'd0:    w_align_lo = 3'd0;
            2'd1:    w_align_lo = 3'd1;
            2'd2:    w_align_lo = 3'd3;
            default: w_align_lo = 3'd7;
        endcase
        w_misalign = |(bus.in_addr[OFF_W-1:0] & OFF_W'(w_align_lo));
        w_illegal  = (bus.in_funct3 == 3'b111)
                   | (bus.in_we & bus.in_funct3[2])
                   | ((DATA_W == 32) && (bus.in_funct3[1:0] == 2'b11));
    end

    always_comb begin
        state_d         = state_q;
        in_ready_d      = in_ready_q;
        out_valid_d     = out_valid_q;
        out_err_d       = out_err_q;
        out_rdata_d     = out_rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        we_d            = we_q;
        funct3_d        = funct3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    we_d       = bus.in_we;
                    funct3_d   = bus.in_funct3;
                    addr_d     = bus.in_addr;
                    wdata_d    = bus.in_wdata;
                    in_ready_d = 1'b0;
                    if (w_misalign || w_illegal) begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = '0;
                    end else begin
                        state_d         = ST_REQ;
                        mem_req_valid_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    // A response may arrive in the very handshake cycle.
                    if (bus.mem_rsp_valid) begin
                        state_d     = ST_RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = bus.mem_rsp_err;
                        out_rdata_d = we_q ? '0 : w_rdata_ext;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d     = ST_RESP;
                    out_valid_d = 1'b1;
                    out_err_d   = bus.mem_rsp_err;
                    out_rdata_d = we_q ? '0 : w_rdata_ext;
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            out_err_q       <= 1'b0;
            out_rdata_q     <= '0;
            mem_req_valid_q <= 1'b0;
            we_q            <= 1'b0;
            funct3_q        <= 3'b000;
            addr_q          <= '0;
            wdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            out_err_q       <= out_err_d;
            out_rdata_q     <= out_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            we_q            <= we_d;
            funct3_q        <= funct3_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_err       = out_err_q;
    assign bus.out_rdata     = out_rdata_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_we    = mem_req_valid_q & we_q;
    assign bus.mem_req_addr  = {addr_q[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.mem_req_wdata = w_wdata_sh;
    assign bus.mem_req_wstrb = (mem_req_valid_q & we_q) ? w_wstrb : '0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
// ============================================================================
// Module      : tb_lsu_mem_ctrl
// Description : Directed, table-driven bench for 32- and 64-bit LSU instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // sel picks which instance receives stimulus and is observed: 0=32b, 1=64b
    logic        sel;
    logic        t_in_valid, t_we, t_out_ready, t_req_ready, t_rsp_valid, t_rsp_err;
    logic [2:0]  t_funct3;
    logic [63:0] t_addr, t_wdata, t_rsp_rdata;

    lsu_mem_ctrl_if #(.DATA_W(32)) if32 ();
    lsu_mem_ctrl_if #(.DATA_W(64)) if64 ();

    assign if32.in_valid      = t_in_valid & ~sel;
    assign if32.in_we         = t_we;
    assign if32.in_funct3     = t_funct3;
    assign if32.in_addr       = t_addr[31:0];
    assign if32.in_wdata      = t_wdata[31:0];
    assign if32.out_ready     = t_out_ready;
    assign if32.mem_req_ready = t_req_ready;
    assign if32.mem_rsp_valid = t_rsp_valid & ~sel;
    assign if32.mem_rsp_rdata = t_rsp_rdata[31:0];
    assign if32.mem_rsp_err   = t_rsp_err;

    assign if64.in_valid      = t_in_valid & sel;
    assign if64.in_we         = t_we;
    assign if64.in_funct3     = t_funct3;
    assign if64.in_addr       = t_addr;
    assign if64.in_wdata      = t_wdata;
    assign if64.out_ready     = t_out_ready;
    assign if64.mem_req_ready = t_req_ready;
    assign if64.mem_rsp_valid = t_rsp_valid & sel;
    assign if64.mem_rsp_rdata = t_rsp_rdata;
    assign if64.mem_rsp_err   = t_rsp_err;

    lsu_mem_ctrl #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    lsu_mem_ctrl #(.DATA_W(64)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    logic        o_in_ready, o_out_valid, o_out_err, o_req_valid, o_req_we;
    logic [63:0] o_out_rdata, o_req_addr, o_req_wdata;
    logic [7:0]  o_req_wstrb;

    always_comb begin
        if (sel) begin
            o_in_ready  = if64.in_ready;
            o_out_valid = if64.out_valid;
            o_out_err   = if64.out_err;
            o_out_rdata = if64.out_rdata;
            o_req_valid = if64.mem_req_valid;
            o_req_we    = if64.mem_req_we;
            o_req_addr  = if64.mem_req_addr;
            o_req_wdata = if64.mem_req_wdata;
            o_req_wstrb = if64.mem_req_wstrb;
        end else begin
            o_in_ready  = if32.in_ready;
            o_out_valid = if32.out_valid;
            o_out_err   = if32.out_err;
            o_out_rdata = {32'h0, if32.out_rdata};
            o_req_valid = if32.mem_req_valid;
            o_req_we    = if32.mem_req_we;
            o_req_addr  = {32'h0, if32.mem_req_addr};
            o_req_wdata = {32'h0, if32.mem_req_wdata};
            o_req_wstrb = {4'h0, if32.mem_req_wstrb};
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic        w64;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] raw;
        logic        rsp_err;
        logic        mis;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        logic [63:0] e_rdata;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic w64,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] raw, input logic rsp_err, input logic mis,
                                input logic [63:0] e_addr, input logic [63:0] e_wdata,
                                input logic [7:0] e_wstrb, input logic [63:0] e_rdata,
                                input logic e_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.w64 = w64; v.addr = addr; v.wdata = wdata;
        v.raw = raw; v.rsp_err = rsp_err; v.mis = mis; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  {63'h0, o_in_ready},  64'h1);
        chk({tag, "_out_valid"}, {63'h0, o_out_valid}, 64'h0);
        chk({tag, "_req_valid"}, {63'h0, o_req_valid}, 64'h0);
        chk({tag, "_req_we"},    {63'h0, o_req_we},    64'h0);
        chk({tag, "_wstrb"},     {56'h0, o_req_wstrb}, 64'h0);
    endtask

    // Zero-wait memory and immediate out_ready: latencies are fixed.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        sel = v.w64;
        #1;
        chk({tag, "_in_ready"}, {63'h0, o_in_ready}, 64'h1);
        t_in_valid = 1'b1;
        t_we       = v.we;
        t_funct3   = v.f3;
        t_addr     = v.addr;
        t_wdata    = v.wdata;
        @(negedge clk);
        t_in_valid = 1'b0;
        chk({tag, "_busy"}, {63'h0, o_in_ready}, 64'h0);
        if (v.mis) begin
            chk({tag, "_no_req"},    {63'h0, o_req_valid}, 64'h0);
            chk({tag, "_err_valid"}, {63'h0, o_out_valid}, 64'h1);
        end else begin
            chk({tag, "_req_valid"}, {63'h0, o_req_valid}, 64'h1);
            chk({tag, "_req_we"},    {63'h0, o_req_we},    {63'h0, v.we});
            chk({tag, "_req_addr"},  o_req_addr,           v.e_addr);
            chk({tag, "_req_wdata"}, o_req_wdata,          v.e_wdata);
            chk({tag, "_req_wstrb"}, {56'h0, o_req_wstrb}, {56'h0, v.e_wstrb});
            t_req_ready = 1'b1;
            t_rsp_valid = 1'b1;
            t_rsp_rdata = v.raw;
            t_rsp_err   = v.rsp_err;
            @(negedge clk);
            t_req_ready = 1'b0;
            t_rsp_valid = 1'b0;
            t_rsp_err   = 1'b0;
            chk({tag, "_out_valid"}, {63'h0, o_out_valid}, 64'h1);
            chk({tag, "_req_done"},  {63'h0, o_req_valid}, 64'h0);
        end
        chk({tag, "_rdata"}, o_out_rdata,         v.e_rdata);
        chk({tag, "_err"},   {63'h0, o_out_err},  {63'h0, v.e_err});
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        chk({tag, "_out_clr"}, {63'h0, o_out_valid}, 64'h0);
        chk({tag, "_ready"},   {63'h0, o_in_ready},  64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            we f3   w64 addr                   wdata                  raw                    re mis e_addr                 e_wdata                e_wstrb e_rdata                e_err
        vecs[0]  = mk(1, SB,  0, 64'h8000_0003,          64'hAB,                64'h0,                 0, 0, 64'h8000_0000,          64'hAB00_0000,         8'h08, 64'h0,                 0);
        vecs[1]  = mk(0, LH,  0, 64'h8000_0002,          64'h0,                 64'h8123_4567,         0, 0, 64'h8000_0000,          64'h0,                 8'h00, 64'hFFFF_8123,         0);
        vecs[2]  = mk(0, LHU, 0, 64'h8000_0002,          64'h0,                 64'h8123_4567,         0, 0, 64'h8000_0000,          64'h0,                 8'h00, 64'h0000_8123,         0);
        vecs[3]  = mk(0, LW,  0, 64'h8000_0001,          64'h0,                 64'h0,                 0, 1, 64'h0,                  64'h0,                 8'h00, 64'h0,                 1);
        vecs[4]  = mk(0, LB,  0, 64'h8000_0001,          64'h0,                 64'h1234_8000,         0, 0, 64'h8000_0000,          64'h0,                 8'h00, 64'hFFFF_FF80,         0);
        vecs[5]  = mk(0, LBU, 0, 64'h8000_0001,          64'h0,                 64'h1234_8000,         0, 0, 64'h8000_0000,          64'h0,                 8'h00, 64'h0000_0080,         0);
        vecs[6]  = mk(1, SH,  0, 64'h1002,               64'h1234_BEEF,         64'h0,                 1, 0, 64'h1000,               64'hBEEF_0000,         8'h0C, 64'h0,                 1);
        vecs[7]  = mk(0, LW,  0, 64'h1004,               64'h0,                 64'hDEAD_BEEF,         0, 0, 64'h1004,               64'h0,                 8'h00, 64'hDEAD_BEEF,         0);
        vecs[8]  = mk(0, LD,  0, 64'h0,                  64'h0,                 64'h0,                 0, 1, 64'h0,                  64'h0,                 8'h00, 64'h0,                 1);
        vecs[9]  = mk(1, SH,  0, 64'h1001,               64'h55,                64'h0,                 0, 1, 64'h0,                  64'h0,                 8'h00, 64'h0,                 1);
        vecs[10] = mk(1, 3'b110, 0, 64'h1000,            64'h55,                64'h0,                 0, 1, 64'h0,                  64'h0,                 8'h00, 64'h0,                 1);
        vecs[11] = mk(1, SW,  0, 64'h8000_0004,          64'h1122_3344,         64'h0,                 0, 0, 64'h8000_0004,          64'h1122_3344,         8'h0F, 64'h0,                 0);
        vecs[12] = mk(0, LD,  1, 64'h10,                 64'h0,                 64'h8000_0000_0000_0001, 0, 0, 64'h10,               64'h0,                 8'h00, 64'h8000_0000_0000_0001, 0);
        vecs[13] = mk(1, SW,  1, 64'h14,                 64'hCAFE_BABE,         64'h0,                 0, 0, 64'h10,                 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0,               0);
        vecs[14] = mk(0, LW,  1, 64'h14,                 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 64'h10,               64'h0,                 8'h00, 64'hFFFF_FFFF_8765_4321, 0);
        vecs[15] = mk(0, LWU, 1, 64'h14,                 64'h0,                 64'h8765_4321_0000_0000, 0, 0, 64'h10,               64'h0,                 8'h00, 64'h0000_0000_8765_4321, 0);
        vecs[16] = mk(0, LD,  1, 64'h14,                 64'h0,                 64'h0,                 0, 1, 64'h0,                  64'h0,                 8'h00, 64'h0,                 1);
        vecs[17] = mk(1, SD,  1, 64'h8,                  64'h0123_4567_89AB_CDEF, 64'h0,               0, 0, 64'h8,                  64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,               0);
        vecs[18] = mk(1, SB,  1, 64'h17,                 64'h5A,                64'h0,                 0, 0, 64'h10,                 64'h5A00_0000_0000_0000, 8'h80, 64'h0,               0);
        vecs[19] = mk(0, LH,  1, 64'h16,                 64'h0,                 64'hBEEF_0000_0000_0000, 0, 0, 64'h10,               64'h0,                 8'h00, 64'hFFFF_FFFF_FFFF_BEEF, 0);
        vecs[20] = mk(1, SB,  1, 64'h13,                 64'h5A,                64'h0,                 0, 0, 64'h10,                 64'h0000_0000_5A00_0000, 8'h08, 64'h0,               0);

        rst = 1'b1; sel = 1'b0;
        t_in_valid = 1'b0; t_we = 1'b0; t_funct3 = 3'b000; t_addr = '0; t_wdata = '0;
        t_out_ready = 1'b0; t_req_ready = 1'b0; t_rsp_valid = 1'b0; t_rsp_rdata = '0; t_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances
        sel = 1'b0; #1;
        chk_idle("rst32");
        chk("rst32_rdata", o_out_rdata, 64'h0);
        chk("rst32_err", {63'h0, o_out_err}, 64'h0);
        sel = 1'b1; #1;
        chk_idle("rst64");
        chk("rst64_rdata", o_out_rdata, 64'h0);
        chk("rst64_err", {63'h0, o_out_err}, 64'h0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Stalled request, slow memory and slow WBU on the 32-bit instance
        @(negedge clk);
        sel = 1'b0;
        t_in_valid = 1'b1; t_we = 1'b0; t_funct3 = LW; t_addr = 64'h2000; t_wdata = '0;
        @(negedge clk);
        t_in_valid = 1'b0;
        repeat (3) begin
            chk("stall_req_valid", {63'h0, o_req_valid}, 64'h1);
            chk("stall_req_addr",  o_req_addr,           64'h2000);
            chk("stall_in_ready",  {63'h0, o_in_ready},  64'h0);
            @(negedge clk);
        end
        t_req_ready = 1'b1;
        chk("stall_req_hs", {63'h0, o_req_valid}, 64'h1);
        @(negedge clk);
        t_req_ready = 1'b0;
        repeat (5) begin
            chk("wait_req_valid", {63'h0, o_req_valid}, 64'h0);
            chk("wait_out_valid", {63'h0, o_out_valid}, 64'h0);
            chk("wait_in_ready",  {63'h0, o_in_ready},  64'h0);
            @(negedge clk);
        end
        t_rsp_valid = 1'b1; t_rsp_rdata = 64'hA5A5_0001;
        @(negedge clk);
        t_rsp_valid = 1'b0; t_rsp_rdata = 64'h0;
        repeat (2) begin
            chk("hold_out_valid", {63'h0, o_out_valid}, 64'h1);
            chk("hold_rdata",     o_out_rdata,          64'hA5A5_0001);
            chk("hold_in_ready",  {63'h0, o_in_ready},  64'h0);
            @(negedge clk);
        end
        t_out_ready = 1'b1;
        @(negedge clk);
        t_out_ready = 1'b0;
        chk("hold_done_valid", {63'h0, o_out_valid}, 64'h0);
        chk("hold_done_ready", {63'h0, o_in_ready},  64'h1);

        // Reset while waiting for a response, then a stray response
        @(negedge clk);
        t_in_valid = 1'b1; t_we = 1'b0; t_funct3 = LW; t_addr = 64'h3000;
        @(negedge clk);
        t_in_valid = 1'b0; t_req_ready = 1'b1;
        @(negedge clk);
        t_req_ready = 1'b0;
        chk("abort_waiting", {63'h0, o_in_ready}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("abort_rst");
        t_rsp_valid = 1'b1; t_rsp_rdata = 64'h1234;
        @(negedge clk);
        t_rsp_valid = 1'b0;
        repeat (3) begin
            chk("stray_out_valid", {63'h0, o_out_valid}, 64'h0);
            chk("stray_in_ready",  {63'h0, o_in_ready},  64'h1);
            @(negedge clk);
        end
        run_vec(100, vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
